// File: rtl/eth_tx_arb_if.sv
// eth_tx_arb_if: 64-bit AXI-Stream bundle shared by the arbiter inputs and output.
// master drives the beat, slave drives tready.
interface eth_tx_arb_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        tready;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-granular 2:1 AXI-Stream arbiter for the 10G MAC TX port.
// Pass-through data path, programmable inter-frame gap, beat watchdog abort.
module eth_tx_arb #(
    parameter int C_STRICT   = 0,
    parameter int IFG_CYCLES = 1,
    parameter int MAX_BEATS  = 1200
) (
    input  logic         tx_clk,
    input  logic         tx_reset,
    eth_tx_arb_if.slave  s0,
    eth_tx_arb_if.slave  s1,
    eth_tx_arb_if.master m,
    output logic [15:0]  frm_cnt0,
    output logic [15:0]  frm_cnt1,
    output logic         trunc_err,
    output logic [3:0]   arb_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_XFER  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;

    localparam logic [2:0]  S_AFTER  = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
    localparam logic [15:0] LAST_IDX = 16'(MAX_BEATS - 1);
    localparam logic [3:0]  GAP_LAST = 4'(IFG_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] frm0_q, frm0_d;
    logic [15:0] frm1_q, frm1_d;
    logic        trunc_q, trunc_d;
    logic [63:0] data_q;
    logic [7:0]  keep_q;

    logic [63:0] g_tdata;
    logic [7:0]  g_tkeep;
    logic        g_tvalid, g_tlast, g_tuser;
    logic        xfer, drain, at_max, trunc_beat;
    logic        g_ready, acc, pick1;

    assign g_tdata  = grant_q ? s1.tdata  : s0.tdata;
    assign g_tkeep  = grant_q ? s1.tkeep  : s0.tkeep;
    assign g_tvalid = grant_q ? s1.tvalid : s0.tvalid;
    assign g_tlast  = grant_q ? s1.tlast  : s0.tlast;
    assign g_tuser  = grant_q ? s1.tuser  : s0.tuser;

    assign xfer       = (state_q == S_XFER);
    assign drain      = (state_q == S_DRAIN);
    assign at_max     = (beat_cnt_q == LAST_IDX);
    assign trunc_beat = xfer & at_max & ~g_tlast;

    // Watchdog abort rewrites the runaway beat as a bad end-of-frame.
    assign m.tvalid = xfer & g_tvalid;
    assign m.tlast  = xfer & (g_tlast | at_max);
    assign m.tuser  = xfer & (g_tuser | trunc_beat);
    assign m.tdata  = xfer ? g_tdata : data_q;
    assign m.tkeep  = xfer ? g_tkeep : keep_q;

    assign g_ready   = (xfer & m.tready) | drain;
    assign s0.tready = ~grant_q & g_ready;
    assign s1.tready = grant_q & g_ready;
    assign acc       = m.tvalid & m.tready;

    // Round-robin only breaks ties; a lone requester always wins.
    assign pick1 = (C_STRICT != 0)
                 ? s1.tvalid
                 : s1.tvalid & (~s0.tvalid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        frm0_d       = frm0_q;
        frm1_d       = frm1_q;
        trunc_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (s0.tvalid | s1.tvalid) begin
                    grant_d = pick1;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (acc) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (g_tlast | at_max) begin
                        beat_cnt_d   = 16'd0;
                        gap_cnt_d    = 4'd0;
                        last_grant_d = grant_q;
                        if (grant_q) frm1_d = frm1_q + 16'd1;
                        else         frm0_d = frm0_q + 16'd1;
                        trunc_d = trunc_beat;
                        state_d = trunc_beat ? S_DRAIN : S_AFTER;
                    end
                end
            end
            S_DRAIN: begin
                if (g_tvalid & g_tlast) begin
                    gap_cnt_d = 4'd0;
                    state_d   = S_AFTER;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
                else gap_cnt_d = gap_cnt_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or posedge tx_reset) begin
        if (tx_reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 16'd0;
            gap_cnt_q    <= 4'd0;
            frm0_q       <= 16'd0;
            frm1_q       <= 16'd0;
            trunc_q      <= 1'b0;
            data_q       <= 64'd0;
            keep_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            frm0_q       <= frm0_d;
            frm1_q       <= frm1_d;
            trunc_q      <= trunc_d;
            if (xfer) begin
                data_q <= g_tdata;
                keep_q <= g_tkeep;
            end
        end
    end

    assign frm_cnt0  = frm0_q;
    assign frm_cnt1  = frm1_q;
    assign trunc_err = trunc_q;
    assign arb_dbg   = {grant_q, state_q};

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: randomized scoreboard bench for eth_tx_arb.
// Frame-level model predicts output beats; a strict-priority instance runs a directed check.
module tb_eth_tx_arb;

    localparam int IFG  = 2;
    localparam int MAXB = 10;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
        logic        t;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_tx_arb_if s0_if ();
    eth_tx_arb_if s1_if ();
    eth_tx_arb_if m_if ();
    eth_tx_arb_if ss0_if ();
    eth_tx_arb_if ss1_if ();
    eth_tx_arb_if sm_if ();

    logic [63:0] sd[2] = '{64'd0, 64'd0};
    logic [7:0]  sk[2] = '{8'd0, 8'd0};
    logic        sv[2] = '{1'b0, 1'b0};
    logic        sl[2] = '{1'b0, 1'b0};
    logic        su[2] = '{1'b0, 1'b0};
    logic        st_rdy[2];
    logic        mrdy = 1'b1;

    logic [63:0] pd[2] = '{64'd0, 64'd0};
    logic        pv[2] = '{1'b0, 1'b0};
    logic        pl[2] = '{1'b0, 1'b0};
    logic        prdy[2];

    logic [15:0] fc0, fc1, sfc0, sfc1;
    logic        te, ste;
    logic [3:0]  dbg, sdbg;

    assign s0_if.tdata  = sd[0];
    assign s0_if.tkeep  = sk[0];
    assign s0_if.tvalid = sv[0];
    assign s0_if.tlast  = sl[0];
    assign s0_if.tuser  = su[0];
    assign s1_if.tdata  = sd[1];
    assign s1_if.tkeep  = sk[1];
    assign s1_if.tvalid = sv[1];
    assign s1_if.tlast  = sl[1];
    assign s1_if.tuser  = su[1];
    assign st_rdy[0]    = s0_if.tready;
    assign st_rdy[1]    = s1_if.tready;
    assign m_if.tready  = mrdy;

    assign ss0_if.tdata  = pd[0];
    assign ss0_if.tkeep  = 8'hff;
    assign ss0_if.tvalid = pv[0];
    assign ss0_if.tlast  = pl[0];
    assign ss0_if.tuser  = 1'b0;
    assign ss1_if.tdata  = pd[1];
    assign ss1_if.tkeep  = 8'hff;
    assign ss1_if.tvalid = pv[1];
    assign ss1_if.tlast  = pl[1];
    assign ss1_if.tuser  = 1'b0;
    assign prdy[0]       = ss0_if.tready;
    assign prdy[1]       = ss1_if.tready;
    assign sm_if.tready  = 1'b1;

    eth_tx_arb #(
        .C_STRICT   (0),
        .IFG_CYCLES (IFG),
        .MAX_BEATS  (MAXB)
    ) dut (
        .tx_clk    (clk),
        .tx_reset  (rst),
        .s0        (s0_if),
        .s1        (s1_if),
        .m         (m_if),
        .frm_cnt0  (fc0),
        .frm_cnt1  (fc1),
        .trunc_err (te),
        .arb_dbg   (dbg)
    );

    eth_tx_arb #(
        .C_STRICT   (1),
        .IFG_CYCLES (IFG),
        .MAX_BEATS  (MAXB)
    ) dut_strict (
        .tx_clk    (clk),
        .tx_reset  (rst),
        .s0        (ss0_if),
        .s1        (ss1_if),
        .m         (sm_if),
        .frm_cnt0  (sfc0),
        .frm_cnt1  (sfc1),
        .trunc_err (ste),
        .arb_dbg   (sdbg)
    );

    int    checks = 0;
    int    errors = 0;
    int    fid = 0;
    int    mfrm[2] = '{0, 0};
    int    rdy_mode = 0;
    bit    drv_en = 1'b0;
    bit    mon_en = 1'b0;
    bit    cont = 1'b0;
    beat_t srcq[2][$];
    beat_t expq[2][$];
    logic  order[$];
    logic  sord[$];

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a frame longer than MAXB is cut at beat MAXB,
    // which becomes an aborted end-of-frame; the remainder never appears.
    task automatic gen_frame(input int s, input int len);
        beat_t b;
        fid++;
        for (int i = 0; i < len; i++) begin
            b.d = {s[0], fid[14:0], i[15:0], $urandom()};
            b.k = 8'($urandom_range(1, 255));
            b.l = (i == len - 1);
            b.u = b.l & ($urandom_range(0, 5) == 0);
            b.t = 1'b0;
            srcq[s].push_back(b);
            if (i < MAXB) begin
                if (i == MAXB - 1 && len > MAXB) begin
                    b.l = 1'b1;
                    b.u = 1'b1;
                    b.t = 1'b1;
                end
                expq[s].push_back(b);
            end
        end
        mfrm[s]++;
    endtask

    task automatic src_drv(input int s);
        logic  acc;
        beat_t b;
        forever begin
            @(negedge clk);
            acc = sv[s] & st_rdy[s];
            @(posedge clk);
            #1;
            if (drv_en) begin
                if (acc && srcq[s].size() > 0) b = srcq[s].pop_front();
                if (srcq[s].size() == 0) sv[s] = 1'b0;
                else if (!(sv[s] && !acc))
                    sv[s] = cont || ($urandom_range(0, 3) != 0);
                if (sv[s]) begin
                    b = srcq[s][0];
                    sd[s] = b.d;
                    sk[s] = b.k;
                    sl[s] = b.l;
                    su[s] = b.u;
                end
            end
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while ((srcq[0].size() + srcq[1].size() + expq[0].size()
                + expq[1].size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, %0d/%0d beats left",
                     nm, n, expq[0].size(), expq[1].size());
        end
        repeat (IFG + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       mrdy = 1'($urandom_range(0, 1));
                2:       mrdy = ~mrdy;
                default: mrdy = 1'b1;
            endcase
        end
    end

    // Monitor: pops the expected beat of whichever source the data tags.
    initial begin
        beat_t e;
        int    src;
        bit    in_frame = 1'b0;
        bit    have_prev = 1'b0;
        bit    te_pend = 1'b0;
        int    idle = 0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                in_frame  = 1'b0;
                have_prev = 1'b0;
                te_pend   = 1'b0;
                idle      = 0;
            end else begin
                chk("trunc_err", te, te_pend);
                te_pend = 1'b0;
                if (m_if.tvalid) begin
                    src = int'(m_if.tdata[63]);
                    chk("src_ready", {st_rdy[src], st_rdy[1-src]},
                        {mrdy, 1'b0});
                    if (!in_frame) begin
                        if (have_prev && cont)
                            chk("gap_exact", idle, IFG + 1);
                        else if (have_prev)
                            chk("gap_min", idle >= IFG + 1, 1);
                        in_frame = 1'b1;
                    end
                    if (mrdy) begin
                        if (expq[src].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL beat_extra: got %0h expected none",
                                     m_if.tdata);
                        end else begin
                            e = expq[src].pop_front();
                            chk("beat", {m_if.tdata, m_if.tkeep, m_if.tlast,
                                         m_if.tuser}, {e.d, e.k, e.l, e.u});
                            if (e.l) begin
                                order.push_back(src[0]);
                                in_frame  = 1'b0;
                                have_prev = 1'b1;
                                idle      = 0;
                                te_pend   = e.t;
                            end
                        end
                    end
                end else if (!in_frame) begin
                    idle++;
                end
            end
        end
    end

    task automatic strict_run();
        logic acc[2];
        logic bi[2] = '{1'b0, 1'b0};
        bit   en1 = 1'b1;
        int   k1 = 0, n0 = 0, n1 = 0;
        chk("strict_dbg_idle", sdbg, 4'b0000);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (sm_if.tvalid && sm_if.tlast) sord.push_back(sm_if.tdata[63]);
            chk("strict_trunc", ste, 1'b0);
            for (int s = 0; s < 2; s++) acc[s] = pv[s] & prdy[s];
            @(posedge clk);
            #1;
            if (acc[1] && bi[1] && cyc >= 50) en1 = 1'b0;
            for (int s = 0; s < 2; s++) if (acc[s]) bi[s] = ~bi[s];
            pv[0] = 1'b1;
            pv[1] = en1 | bi[1];
            for (int s = 0; s < 2; s++) begin
                pl[s] = bi[s];
                pd[s] = {s[0], 62'(cyc), bi[s]};
            end
        end
        @(posedge clk);
        #1;
        while (k1 < sord.size() && sord[k1]) k1++;
        foreach (sord[i]) if (sord[i]) n1++; else n0++;
        chk("strict_first_s1", sord[0], 1'b1);
        chk("strict_s1_run", k1 >= 8, 1);
        chk("strict_s0_after", n0, sord.size() - k1);
        chk("strict_s0_served", n0 >= 5, 1);
        chk("strict_cnt0", sfc0, n0);
        chk("strict_cnt1", sfc1, n1);
        pv[0] = 1'b0;
        pv[1] = 1'b0;
    endtask

    initial begin
        bit got;
        fork
            src_drv(0);
            src_drv(1);
        join_none

        #12;
        chk("rst_tvalid", m_if.tvalid, 1'b0);
        chk("rst_tlast_tuser", {m_if.tlast, m_if.tuser}, 2'b00);
        chk("rst_tdata_tkeep", {m_if.tdata, m_if.tkeep}, 72'd0);
        chk("rst_tready", {st_rdy[0], st_rdy[1]}, 2'b00);
        chk("rst_cnts", {fc0, fc1, te}, 33'd0);
        chk("rst_dbg", dbg, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Both sources always ready with 2-beat frames.
        mon_en = 1'b1;
        drv_en = 1'b1;
        cont   = 1'b1;
        gen_frame(0, 2);
        gen_frame(1, 2);
        gen_frame(0, 2);
        gen_frame(1, 2);
        wait_done("rr_done", 200);
        chk("rr_nfrm", order.size(), 4);
        if (order.size() == 4)
            chk("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
        chk("rr_cnts", {fc0, fc1}, {16'd2, 16'd2});
        cont = 1'b0;

        rdy_mode = 2;
        gen_frame(0, 8);
        wait_done("alt_done", 200);
        rdy_mode = 0;
        chk("alt_cnt0", fc0, mfrm[0][15:0]);

        rdy_mode = 1;
        gen_frame(0, MAXB);
        gen_frame(1, MAXB + 1);
        for (int i = 0; i < 30; i++)
            gen_frame($urandom_range(0, 1), $urandom_range(1, MAXB + 3));
        wait_done("rand_done", 20000);
        rdy_mode = 0;
        chk("rand_cnt0", fc0, mfrm[0][15:0]);
        chk("rand_cnt1", fc1, mfrm[1][15:0]);

        // Reset in the middle of a frame.
        drv_en = 1'b0;
        mon_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sv[0] = 1'b1;
        sd[0] = 64'h1111_0000_0000_0001;
        sk[0] = 8'hff;
        sl[0] = 1'b0;
        su[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (m_if.tvalid && mrdy) got = 1'b1;
        end
        chk("mid_beat1", got, 1'b1);
        @(posedge clk);
        #1;
        sd[0] = 64'h2222_0000_0000_0002;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_tvalid", m_if.tvalid, 1'b0);
        chk("mid_tready", {st_rdy[0], st_rdy[1]}, 2'b00);
        chk("mid_cnts", {fc0, fc1}, 32'd0);
        chk("mid_dbg", dbg, 4'b0000);
        sv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        srcq[0].delete();
        srcq[1].delete();
        expq[0].delete();
        expq[1].delete();
        mfrm   = '{0, 0};
        mon_en = 1'b1;
        drv_en = 1'b1;
        gen_frame(0, 3);
        wait_done("post_rst_done", 200);
        chk("post_rst_cnts", {fc0, fc1}, {16'd1, 16'd0});

        strict_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
